// File: rtl/acc_csr_bank.sv
// acc_csr_bank: ICB slave register bank for the convolution accelerator.
// It holds the CTRL and STATUS registers and NUM_CFG byte-maskable config
// words. It allows one ICB command in flight at a time, tracks busy/done
// for the main FSM, and drives a level interrupt.
module acc_csr_bank #(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned NUM_CFG  = 8,
  parameter int unsigned CFG_BASE = 'h010
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   icb_cmd_valid,
  output logic                   icb_cmd_ready,
  input  logic                   icb_cmd_read,
  input  logic [ADDR_W-1:0]      icb_cmd_addr,
  input  logic [31:0]            icb_cmd_wdata,
  input  logic [3:0]             icb_cmd_wmask,
  output logic                   icb_rsp_valid,
  input  logic                   icb_rsp_ready,
  output logic [31:0]            icb_rsp_rdata,
  output logic                   icb_rsp_err,
  output logic [32*NUM_CFG-1:0]  cfg_flat,
  output logic                   start_pulse,
  input  logic                   conv_finish,
  output logic                   busy,
  output logic                   irq
);

  localparam int unsigned WA_W = ADDR_W - 2;

  // Decoding is done on word addresses. addr[1:0] is used only for the alignment check.
  localparam logic [WA_W-1:0] CTRL_WA     = '0;
  localparam logic [WA_W-1:0] STATUS_WA   = WA_W'(1);
  localparam logic [WA_W-1:0] CFG_BASE_WA = WA_W'(CFG_BASE / 4);
  localparam logic [WA_W-1:0] CFG_END_WA  = WA_W'(CFG_BASE / 4 + NUM_CFG);

  logic [31:0]     cfg [NUM_CFG];
  logic            irq_en;
  logic            done;
  logic [7:0]      done_cnt;

  logic            accept;
  logic            wr;
  logic            aligned;
  logic [WA_W-1:0] word_addr;
  logic [WA_W-1:0] cfg_word;
  logic            hit_ctrl;
  logic            hit_status;
  logic            hit_cfg;
  logic            addr_err;
  logic            start_req;
  logic            start_ok;
  logic            cfg_wr_ok;
  logic            finish_ok;
  logic            done_clr;
  logic            cmd_err;
  logic [31:0]     rd_data;

  // Merge write data into an existing word, one byte enable per byte lane.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int unsigned b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

  assign icb_cmd_ready = !icb_rsp_valid;
  assign irq           = done & irq_en;

  // Decode the address, classify the command, and form the read data from pre-edge state.
  always_comb begin
    accept     = icb_cmd_valid & icb_cmd_ready;
    wr         = accept & !icb_cmd_read;
    aligned    = (icb_cmd_addr[1:0] == 2'b00);
    word_addr  = icb_cmd_addr[ADDR_W-1:2];
    cfg_word   = word_addr - CFG_BASE_WA;
    hit_ctrl   = aligned && (word_addr == CTRL_WA);
    hit_status = aligned && (word_addr == STATUS_WA);
    hit_cfg    = aligned && (word_addr >= CFG_BASE_WA) && (word_addr < CFG_END_WA);
    addr_err   = !(hit_ctrl || hit_status || hit_cfg);

    // The START decision uses pre-edge busy. A same-edge conv_finish cannot re-enable it.
    start_req  = wr & hit_ctrl & icb_cmd_wmask[0] & icb_cmd_wdata[0];
    start_ok   = start_req & !busy;
    cfg_wr_ok  = wr & hit_cfg & !busy;
    finish_ok  = conv_finish & busy;
    done_clr   = wr & hit_status & icb_cmd_wmask[0] & icb_cmd_wdata[1];

    cmd_err    = addr_err | (start_req & busy) | (!icb_cmd_read & hit_cfg & busy);

    rd_data = '0;
    if (hit_ctrl) begin
      rd_data = {30'b0, irq_en, 1'b0};
    end else if (hit_status) begin
      rd_data = {16'b0, done_cnt, 6'b0, done, busy};
    end else if (hit_cfg) begin
      for (int unsigned i = 0; i < NUM_CFG; i++) begin
        if (cfg_word == WA_W'(i)) rd_data = cfg[i];
      end
    end
  end

  // Response channel: latch the response at accept, hold it until rsp_ready, then release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      icb_rsp_valid <= 1'b0;
      icb_rsp_rdata <= '0;
      icb_rsp_err   <= 1'b0;
    end else if (accept) begin
      icb_rsp_valid <= 1'b1;
      icb_rsp_err   <= cmd_err;
      icb_rsp_rdata <= (icb_cmd_read && !cmd_err) ? rd_data : '0;
    end else if (icb_rsp_ready) begin
      icb_rsp_valid <= 1'b0;
    end
  end

  // Control and status: IRQ_EN, job start/busy tracking, sticky DONE and completion count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_en      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      done_cnt    <= '0;
      start_pulse <= 1'b0;
    end else begin
      start_pulse <= start_ok;
      if (wr && hit_ctrl && icb_cmd_wmask[0]) irq_en <= icb_cmd_wdata[1];
      // start_ok needs busy=0 and finish_ok needs busy=1, so at most one of them fires.
      if (start_ok) begin
        busy <= 1'b1;
      end else if (finish_ok) begin
        busy <= 1'b0;
      end
      // A completion has priority over a same-cycle write-1-clear of DONE.
      if (finish_ok) begin
        done     <= 1'b1;
        done_cnt <= done_cnt + 8'd1;
      end else if (done_clr) begin
        done <= 1'b0;
      end
    end
  end

  // Config words: byte-masked writes, accepted only while no job is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_CFG; i++) cfg[i] <= '0;
    end else if (cfg_wr_ok) begin
      for (int unsigned i = 0; i < NUM_CFG; i++) begin
        if (cfg_word == WA_W'(i)) cfg[i] <= byte_merge(cfg[i], icb_cmd_wdata, icb_cmd_wmask);
      end
    end
  end

  // Expose the config words as one flat vector for the datapath.
  always_comb begin
    cfg_flat = '0;
    for (int unsigned i = 0; i < NUM_CFG; i++) cfg_flat[32*i +: 32] = cfg[i];
  end

endmodule

// File: doc/acc_csr_bank.md
# acc_csr_bank

Parametrised ICB slave control/status register bank for the convolution accelerator, placed between the core's ICB bus and the main FSM. It generalises the fixed accelerator register set in three ways:
- NUM_CFG configuration words with byte-masked writes.
- A proper single-outstanding handshake with response back-pressure and error reporting.
- Busy/done tracking with write-1-to-clear status, a wrapping completion counter and an interrupt output.

## Interface
Parameters:
- ADDR_W, 12, ICB address bits decoded; upper bits are ignored.
- NUM_CFG, 8, number of 32-bit config registers (1..64).
- CFG_BASE, 'h010, byte offset of cfg[0]; cfg[i] lives at CFG_BASE+4*i.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- icb_cmd_valid  in  1  command valid
- icb_cmd_ready  out  1  command ready
- icb_cmd_read  in  1  1=read, 0=write
- icb_cmd_addr  in  ADDR_W  byte address
- icb_cmd_wdata  in  32  write data
- icb_cmd_wmask  in  4  byte enables, bit k covers wdata[8k+7:8k]
- icb_rsp_valid  out  1  response valid
- icb_rsp_ready  in  1  response accepted
- icb_rsp_rdata  out  32  read data; 0 for writes and errors
- icb_rsp_err  out  1  error flag for the response
- cfg_flat  out  32*NUM_CFG  cfg[i] at bits [32i+31:32i]
- start_pulse  out  1  one-cycle job start to main FSM
- conv_finish  in  1  one-cycle job completion from main FSM
- busy  out  1  job in flight
- irq  out  1  level interrupt = done & irq_en

## Operation
Address map (byte offsets; addr[1:0] must be 0):
- 'h000 CTRL (RW): bit0 START, write-1 only, reads 0; bit1 IRQ_EN.
- 'h004 STATUS: bit0 BUSY (RO); bit1 DONE, sticky, write-1-clear; bits[15:8] DONE_CNT (RO).
- CFG_BASE+4*i CFG[i] (RW), byte-masked.

Writes and side effects:
- Writes take effect at the accept edge (icb_cmd_valid & icb_cmd_ready).
- Byte masking applies to CTRL, STATUS and CFG; a masked-off byte leaves its bits unchanged.
- START=1 written while busy=0: start_pulse=1 for the following cycle and busy set.
- START=1 written while busy=1: no start, no busy change, rsp_err=1. IRQ_EN in the same write still updates.
- CFG write while busy=1: ignored, rsp_err=1. CFG reads are always allowed.
- Writes to RO bits are silently dropped (no error).

Completion:
- conv_finish with busy=1: busy cleared, DONE set, DONE_CNT incremented (wraps 255->0).
- conv_finish with busy=0: ignored.

Error responses (write has no effect, rdata=0, rsp_err=1):
- Unmapped address.
- Misaligned address.

Precedence:
- conv_finish and a DONE write-1-clear in the same cycle: DONE set wins.
- conv_finish and a START write in the same cycle: the start is judged on pre-edge busy=1, so it is rejected with an error. busy ends 0.

## Timing
Reset values:
- icb_cmd_ready=1, icb_rsp_valid=0, icb_rsp_rdata=0, icb_rsp_err=0.
- All CFG=0, IRQ_EN=0, DONE=0, DONE_CNT=0.
- busy=0, start_pulse=0, irq=0.

Handshake:
- icb_cmd_ready = !icb_rsp_valid (combinational), so at most one command is outstanding.
- Response registered: rsp_valid rises the cycle after accept, with rdata/err stable.
- rsp_valid holds until the cycle with icb_rsp_ready=1, then falls on that edge. The next command may be accepted in the cycle after rsp_valid falls.
- Minimum throughput: one transaction per 2 cycles.

Read timing:
- Read data is sampled at the accept edge, i.e. it reflects state before any same-edge conv_finish update.

Output timing:
- start_pulse: registered, exactly one cycle high, starting the cycle after the START accept.
- busy: high from the same cycle as start_pulse.
- irq: combinational from registered DONE & IRQ_EN.

Reset mid-operation (rst_n low at any time):
- All outputs go to reset values immediately.
- Any pending response is dropped.

## Test plan
- Reset, then read CFG_BASE+4 -> rsp_valid one cycle after accept, rdata=0, err=0. Write 'hDEADBEEF with wmask=4'b0101 -> readback 'h00AD00EF.
- Write CTRL='h3 -> start_pulse high exactly 1 cycle, busy=1. Pulse conv_finish -> busy=0, DONE=1, irq=1, STATUS reads 'h0000_0102.
- While busy: write CTRL='h1 -> err=1, single start pulse total. Write CFG[0]='h5 -> err=1, CFG[0] unchanged.
- Hold icb_rsp_ready=0 for 5 cycles -> rsp_valid, rdata and err stable; icb_cmd_ready=0 throughout; second command accepted only after rsp_ready.
- Read 'hFFC (unmapped) -> err=1, rdata=0. Read 'h006 (misaligned) -> err=1.
- Same cycle: W1C of DONE and conv_finish -> DONE stays 1. 256 completions -> DONE_CNT=0. rst_n low mid-response -> rsp_valid=0 immediately.
